read_out_sched: RTL and testbench

Two-channel frame scheduler for the serial bit-reversal output buffer, the `read_out` datapath.
- Arbitrates frame requests from two coder channels with round-robin priority.
- Streams the granted channel's bits into the buffer with `code_en`, then pads the buffer to drain the last block.
- Qualifies the buffer's serial output with a valid flag, a channel tag and a frame-done pulse.
- Sits between the coder channels and the output serializer.

---
 rtl/read_out_pkg.sv | 22 ++
 rtl/read_out_sched_rr_arb2.sv | 44 ++++
 rtl/read_out_sched.sv | 135 +++++++++++++
 tb/tb_read_out_sched.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/read_out_pkg.sv
// Shared types and constants for the read_out frame scheduler.
package read_out_pkg;

  // Scheduler phases: waiting for a request, streaming a frame, padding the buffer.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_e;

  // Default buffer block size minus one; must match the buffer's own L.
  localparam int DEFAULT_L = 7;

  // Default number of L+1 bit blocks per frame.
  localparam int DEFAULT_BLOCKS = 4;

  // Input-to-output latency of the bit-reversal buffer for a block of l+1 bits.
  function automatic int lat_of(input int l);
    return l + 2;
  endfunction

endpackage

// File: rtl/read_out_sched_rr_arb2.sv
// Two-way round-robin arbiter; the pointer always moves to the channel that did not win.
module rr_arb2
  import read_out_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] req_i,
  input  logic       en_i,
  output logic [1:0] gnt_o
);

  logic ptr_q;
  logic ptr_d;
  logic [1:0] gnt_d;

  // Pick a winner only while enabled; on a tie the pointer decides.
  always_comb begin
    gnt_d = 2'b00;
    ptr_d = ptr_q;
    if (en_i) begin
      case (req_i)
        2'b01:   gnt_d = 2'b01;
        2'b10:   gnt_d = 2'b10;
        2'b11:   gnt_d = ptr_q ? 2'b10 : 2'b01;
        default: gnt_d = 2'b00;
      endcase
      if (gnt_d != 2'b00) begin
        ptr_d = gnt_d[0];
      end
    end
  end

  // Pointer register: after channel 0 wins it points at 1, and vice versa.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign gnt_o = gnt_d;

endmodule

// File: rtl/read_out_sched.sv
// Two-channel frame scheduler in front of the serial bit-reversal buffer:
// arbitrates frames, streams bits into the buffer, pads out the last block
// and qualifies the buffer's serial output.
module read_out_sched
  import read_out_pkg::*;
#(
  parameter int L      = DEFAULT_L,
  parameter int BLOCKS = DEFAULT_BLOCKS,
  parameter int LAT    = lat_of(L)
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] req_i,
  input  logic       bit_in0_i,
  input  logic       bit_in1_i,
  output logic [1:0] gnt_o,
  output logic       buf_bit_o,
  output logic       buf_en_o,
  input  logic       buf_data_i,
  output logic       out_bit_o,
  output logic       out_valid_o,
  output logic       out_ch_o,
  output logic       frame_done_o,
  output logic       busy_o
);

  localparam int BIT_W = (L > 0) ? $clog2(L + 1) : 1;
  localparam int BLK_W = (BLOCKS > 1) ? $clog2(BLOCKS) : 1;
  localparam int FL_W  = $clog2(LAT + 1);

  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(L);
  localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLOCKS - 1);
  localparam logic [FL_W-1:0]  FL_LAST  = FL_W'(LAT - 1);
  localparam logic [FL_W-1:0]  PAD_LAST = FL_W'(L);

  state_e           state_q;
  logic [1:0]       gnt_q;
  logic             ch_q;
  logic             buf_en_q;
  logic [BIT_W-1:0] bit_cnt_q;
  logic [BLK_W-1:0] blk_cnt_q;
  logic [FL_W-1:0]  flush_cnt_q;
  logic [LAT-1:0]   valid_sr_q;

  logic [1:0]       arb_gnt;
  logic             arb_en;

  assign arb_en = (state_q == IDLE);

  rr_arb2 u_arb (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .req_i (req_i),
    .en_i  (arb_en),
    .gnt_o (arb_gnt)
  );

  // Frame sequencer: grant in IDLE, count bits/blocks in RUN, pad then drain in FLUSH.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      gnt_q       <= 2'b00;
      ch_q        <= 1'b0;
      buf_en_q    <= 1'b0;
      bit_cnt_q   <= '0;
      blk_cnt_q   <= '0;
      flush_cnt_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (arb_gnt != 2'b00) begin
            state_q   <= RUN;
            gnt_q     <= arb_gnt;
            ch_q      <= arb_gnt[1];
            buf_en_q  <= 1'b1;
            bit_cnt_q <= '0;
            blk_cnt_q <= '0;
          end
        end

        RUN: begin
          if (bit_cnt_q == BIT_LAST) begin
            bit_cnt_q <= '0;
            if (blk_cnt_q == BLK_LAST) begin
              state_q     <= FLUSH;
              gnt_q       <= 2'b00;
              flush_cnt_q <= '0;
              buf_en_q    <= 1'b1;
            end else begin
              blk_cnt_q <= blk_cnt_q + 1'b1;
            end
          end else begin
            bit_cnt_q <= bit_cnt_q + 1'b1;
          end
        end

        FLUSH: begin
          if (flush_cnt_q == FL_LAST) begin
            state_q     <= IDLE;
            buf_en_q    <= 1'b0;
            flush_cnt_q <= '0;
          end else begin
            flush_cnt_q <= flush_cnt_q + 1'b1;
            buf_en_q    <= (flush_cnt_q < PAD_LAST);
          end
        end

        default: begin
          state_q  <= IDLE;
          gnt_q    <= 2'b00;
          buf_en_q <= 1'b0;
        end
      endcase
    end
  end

  // Valid pipeline: tracks which buffer output cycles carry real frame data.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_sr_q <= '0;
    end else begin
      valid_sr_q <= {valid_sr_q[LAT-2:0], (state_q == RUN)};
    end
  end

  assign gnt_o        = gnt_q;
  assign buf_en_o     = buf_en_q;
  assign buf_bit_o    = (state_q == RUN) ? (ch_q ? bit_in1_i : bit_in0_i) : 1'b0;
  assign out_valid_o  = valid_sr_q[LAT-1];
  assign out_bit_o    = valid_sr_q[LAT-1] & buf_data_i;
  assign frame_done_o = valid_sr_q[LAT-1] & ~valid_sr_q[LAT-2];
  assign out_ch_o     = ch_q;
  assign busy_o       = (state_q != IDLE);

endmodule

// File: tb/tb_read_out_sched.sv
// Directed bench for read_out_sched with a behavioural bit-reversal buffer.
module tb_read_out_sched;

  localparam int L      = 7;
  localparam int BLOCKS = 2;

  logic       clk;
  logic       rst;
  logic [1:0] req;
  logic       bitIn0;
  logic       bitIn1;
  logic [1:0] gnt;
  logic       bufBit;
  logic       bufEn;
  logic       bufData;
  logic       outBit;
  logic       outValid;
  logic       outCh;
  logic       frameDone;
  logic       busy;

  int testsRun;
  int failCount;

  logic [1:0] gntTr     [0:127];
  logic       validTr   [0:127];
  logic       bitTr     [0:127];
  logic       doneTr    [0:127];
  logic       chTr      [0:127];
  logic       busyTr    [0:127];
  logic       enTr      [0:127];
  logic       bufBitTr  [0:127];

  logic [0:15] pat0;
  logic [0:15] pat1;
  int cnt0;
  int cnt1;

  logic mdlCur     [0:L];
  logic mdlPendBlk [0:L];
  logic mdlRd      [0:L];
  int   mdlCnt;
  int   mdlIdx;
  logic mdlPend;
  logic mdlActive;

  read_out_sched #(.L(L), .BLOCKS(BLOCKS)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .req_i        (req),
    .bit_in0_i    (bitIn0),
    .bit_in1_i    (bitIn1),
    .gnt_o        (gnt),
    .buf_bit_o    (bufBit),
    .buf_en_o     (bufEn),
    .buf_data_i   (bufData),
    .out_bit_o    (outBit),
    .out_valid_o  (outValid),
    .out_ch_o     (outCh),
    .frame_done_o (frameDone),
    .busy_o       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Buffer model: collects L+1 enabled bits, then replays them reversed two cycles after the last one.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mdlCnt    <= 0;
      mdlIdx    <= 0;
      mdlPend   <= 1'b0;
      mdlActive <= 1'b0;
    end else begin
      if (mdlPend) begin
        for (int k = 0; k <= L; k++) mdlRd[k] <= mdlPendBlk[k];
        mdlIdx    <= 0;
        mdlActive <= 1'b1;
      end else if (mdlActive) begin
        if (mdlIdx == L) mdlActive <= 1'b0;
        else mdlIdx <= mdlIdx + 1;
      end
      mdlPend <= 1'b0;
      if (bufEn) begin
        mdlCur[mdlCnt] <= bufBit;
        if (mdlCnt == L) begin
          mdlCnt        <= 0;
          mdlPend       <= 1'b1;
          mdlPendBlk[0] <= bufBit;
          for (int k = 1; k <= L; k++) mdlPendBlk[k] <= mdlCur[L-k];
        end else begin
          mdlCnt <= mdlCnt + 1;
        end
      end
    end
  end

  // Outside its replay windows the model drives 1 so masking is exercised.
  assign bufData = mdlActive ? mdlRd[mdlIdx] : 1'b1;

  task automatic doReset;
    req    = 2'b00;
    bitIn0 = 1'b0;
    bitIn1 = 1'b0;
    cnt0   = 0;
    cnt1   = 0;
    rst    = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic runCycles(input int n, input bit autoClear);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      gntTr[i]   = gnt;
      validTr[i] = outValid;
      bitTr[i]   = outBit;
      doneTr[i]  = frameDone;
      chTr[i]    = outCh;
      busyTr[i]  = busy;
      enTr[i]    = bufEn;
      if (gnt[0]) begin bitIn0 = pat0[cnt0 % 16]; cnt0++; end
      else bitIn0 = 1'b1;
      if (gnt[1]) begin bitIn1 = pat1[cnt1 % 16]; cnt1++; end
      else bitIn1 = 1'b1;
      #1;
      bufBitTr[i] = bufBit;
      if (autoClear) req = req & ~gnt;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    req = 2'b11;
    bitIn0 = 1'b1;
    bitIn1 = 1'b1;
    @(negedge clk);
    testsRun++; if (gnt !== 2'b00)   begin failCount++; $display("[TB] FAIL reset_gnt: got %b expected 00", gnt); end
    testsRun++; if (bufEn !== 1'b0)  begin failCount++; $display("[TB] FAIL reset_buf_en: got %b expected 0", bufEn); end
    testsRun++; if (bufBit !== 1'b0) begin failCount++; $display("[TB] FAIL reset_buf_bit: got %b expected 0", bufBit); end
    testsRun++; if (outBit !== 1'b0) begin failCount++; $display("[TB] FAIL reset_out_bit: got %b expected 0", outBit); end
    testsRun++; if (outValid !== 1'b0) begin failCount++; $display("[TB] FAIL reset_out_valid: got %b expected 0", outValid); end
    testsRun++; if (outCh !== 1'b0)  begin failCount++; $display("[TB] FAIL reset_out_ch: got %b expected 0", outCh); end
    testsRun++; if (frameDone !== 1'b0) begin failCount++; $display("[TB] FAIL reset_frame_done: got %b expected 0", frameDone); end
    testsRun++; if (busy !== 1'b0)   begin failCount++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    doReset();
  endtask

  task automatic test_prefill_mask;
    doReset();
    runCycles(6, 1'b0);
    for (int i = 0; i < 6; i++) begin
      testsRun++; if (bitTr[i] !== 1'b0)   begin failCount++; $display("[TB] FAIL prefill_out_bit[%0d]: got %b expected 0", i, bitTr[i]); end
      testsRun++; if (validTr[i] !== 1'b0) begin failCount++; $display("[TB] FAIL prefill_out_valid[%0d]: got %b expected 0", i, validTr[i]); end
    end
  endtask

  task automatic test_single_frame;
    logic [1:0] eg;
    logic ev, eb, ebb;
    int k;
    doReset();
    pat0 = 16'b1000_0000_0000_0001;
    req  = 2'b01;
    runCycles(30, 1'b1);
    for (int i = 0; i < 30; i++) begin
      eg  = (i < 16) ? 2'b01 : 2'b00;
      ev  = (i >= 9) && (i < 25);
      eb  = 1'b0;
      if (ev) begin k = i - 9; eb = pat0[(k / 8) * 8 + 7 - (k % 8)]; end
      ebb = (i < 16) ? pat0[i] : 1'b0;
      testsRun++; if (gntTr[i] !== eg)   begin failCount++; $display("[TB] FAIL single_gnt[%0d]: got %b expected %b", i, gntTr[i], eg); end
      testsRun++; if (validTr[i] !== ev) begin failCount++; $display("[TB] FAIL single_valid[%0d]: got %b expected %b", i, validTr[i], ev); end
      testsRun++; if (bitTr[i] !== eb)   begin failCount++; $display("[TB] FAIL single_out_bit[%0d]: got %b expected %b", i, bitTr[i], eb); end
      testsRun++; if (doneTr[i] !== (i == 24)) begin failCount++; $display("[TB] FAIL single_done[%0d]: got %b expected %b", i, doneTr[i], (i == 24)); end
      testsRun++; if (busyTr[i] !== (i < 25))  begin failCount++; $display("[TB] FAIL single_busy[%0d]: got %b expected %b", i, busyTr[i], (i < 25)); end
      testsRun++; if (enTr[i] !== (i < 24))    begin failCount++; $display("[TB] FAIL single_buf_en[%0d]: got %b expected %b", i, enTr[i], (i < 24)); end
      testsRun++; if (bufBitTr[i] !== ebb)     begin failCount++; $display("[TB] FAIL single_buf_bit[%0d]: got %b expected %b", i, bufBitTr[i], ebb); end
      testsRun++; if (chTr[i] !== 1'b0)        begin failCount++; $display("[TB] FAIL single_out_ch[%0d]: got %b expected 0", i, chTr[i]); end
    end
  endtask

  task automatic test_back_to_back;
    logic eb;
    int k;
    doReset();
    pat0 = 16'b0110_1001_1111_0000;
    pat1 = 16'b1100_1010_0011_0110;
    req  = 2'b11;
    runCycles(60, 1'b1);
    testsRun++; if (gntTr[0]  !== 2'b01) begin failCount++; $display("[TB] FAIL b2b_gnt0_start: got %b expected 01", gntTr[0]); end
    testsRun++; if (gntTr[15] !== 2'b01) begin failCount++; $display("[TB] FAIL b2b_gnt0_end: got %b expected 01", gntTr[15]); end
    testsRun++; if (gntTr[16] !== 2'b00) begin failCount++; $display("[TB] FAIL b2b_gnt_flush: got %b expected 00", gntTr[16]); end
    testsRun++; if (gntTr[25] !== 2'b00) begin failCount++; $display("[TB] FAIL b2b_gnt_idle: got %b expected 00", gntTr[25]); end
    testsRun++; if (busyTr[25] !== 1'b0) begin failCount++; $display("[TB] FAIL b2b_busy_idle: got %b expected 0", busyTr[25]); end
    testsRun++; if (gntTr[26] !== 2'b10) begin failCount++; $display("[TB] FAIL b2b_gnt1_start: got %b expected 10", gntTr[26]); end
    testsRun++; if (gntTr[41] !== 2'b10) begin failCount++; $display("[TB] FAIL b2b_gnt1_end: got %b expected 10", gntTr[41]); end
    testsRun++; if (gntTr[42] !== 2'b00) begin failCount++; $display("[TB] FAIL b2b_gnt1_drop: got %b expected 00", gntTr[42]); end
    testsRun++; if (chTr[24] !== 1'b0)   begin failCount++; $display("[TB] FAIL b2b_out_ch_frame0: got %b expected 0", chTr[24]); end
    testsRun++; if (chTr[50] !== 1'b1)   begin failCount++; $display("[TB] FAIL b2b_out_ch_frame1: got %b expected 1", chTr[50]); end
    testsRun++; if (doneTr[50] !== 1'b1) begin failCount++; $display("[TB] FAIL b2b_done_frame1: got %b expected 1", doneTr[50]); end
    for (int i = 35; i <= 50; i++) begin
      k  = i - 35;
      eb = pat1[(k / 8) * 8 + 7 - (k % 8)];
      testsRun++; if (validTr[i] !== 1'b1) begin failCount++; $display("[TB] FAIL b2b_valid1[%0d]: got %b expected 1", i, validTr[i]); end
      testsRun++; if (bitTr[i] !== eb)     begin failCount++; $display("[TB] FAIL b2b_out_bit1[%0d]: got %b expected %b", i, bitTr[i], eb); end
    end
    testsRun++; if (validTr[51] !== 1'b0) begin failCount++; $display("[TB] FAIL b2b_valid1_end: got %b expected 0", validTr[51]); end
    req = 2'b11;
    runCycles(3, 1'b1);
    testsRun++; if (gntTr[0] !== 2'b01) begin failCount++; $display("[TB] FAIL b2b_ptr_after: got %b expected 01", gntTr[0]); end
  endtask

  task automatic test_fairness;
    logic [1:0] eg;
    doReset();
    req = 2'b11;
    runCycles(106, 1'b0);
    for (int f = 0; f < 4; f++) begin
      eg = (f % 2 == 0) ? 2'b01 : 2'b10;
      testsRun++; if (gntTr[f*26] !== eg)      begin failCount++; $display("[TB] FAIL fair_gnt_frame%0d: got %b expected %b", f, gntTr[f*26], eg); end
      testsRun++; if (gntTr[f*26+15] !== eg)   begin failCount++; $display("[TB] FAIL fair_gnt_last_frame%0d: got %b expected %b", f, gntTr[f*26+15], eg); end
      testsRun++; if (gntTr[f*26+25] !== 2'b00) begin failCount++; $display("[TB] FAIL fair_gap_frame%0d: got %b expected 00", f, gntTr[f*26+25]); end
      testsRun++; if (doneTr[f*26+24] !== 1'b1) begin failCount++; $display("[TB] FAIL fair_done_frame%0d: got %b expected 1", f, doneTr[f*26+24]); end
    end
    req = 2'b00;
  endtask

  task automatic test_reset_mid_run;
    doReset();
    pat1 = 16'b1111_1111_1111_1111;
    req  = 2'b10;
    runCycles(12, 1'b1);
    testsRun++; if (gntTr[11] !== 2'b10) begin failCount++; $display("[TB] FAIL midrst_pre_gnt: got %b expected 10", gntTr[11]); end
    #1;
    rst = 1'b1;
    #1;
    testsRun++; if (gnt !== 2'b00)     begin failCount++; $display("[TB] FAIL midrst_gnt: got %b expected 00", gnt); end
    testsRun++; if (bufEn !== 1'b0)    begin failCount++; $display("[TB] FAIL midrst_buf_en: got %b expected 0", bufEn); end
    testsRun++; if (bufBit !== 1'b0)   begin failCount++; $display("[TB] FAIL midrst_buf_bit: got %b expected 0", bufBit); end
    testsRun++; if (outCh !== 1'b0)    begin failCount++; $display("[TB] FAIL midrst_out_ch: got %b expected 0", outCh); end
    testsRun++; if (busy !== 1'b0)     begin failCount++; $display("[TB] FAIL midrst_busy: got %b expected 0", busy); end
    testsRun++; if (outValid !== 1'b0) begin failCount++; $display("[TB] FAIL midrst_out_valid: got %b expected 0", outValid); end
    @(negedge clk);
    rst  = 1'b0;
    cnt0 = 0;
    cnt1 = 0;
    req  = 2'b10;
    runCycles(20, 1'b1);
    testsRun++; if (gntTr[0] !== 2'b10)  begin failCount++; $display("[TB] FAIL midrst_regrant: got %b expected 10", gntTr[0]); end
    testsRun++; if (chTr[0] !== 1'b1)    begin failCount++; $display("[TB] FAIL midrst_regrant_ch: got %b expected 1", chTr[0]); end
    testsRun++; if (gntTr[15] !== 2'b10) begin failCount++; $display("[TB] FAIL midrst_full_run: got %b expected 10", gntTr[15]); end
    testsRun++; if (gntTr[16] !== 2'b00) begin failCount++; $display("[TB] FAIL midrst_run_end: got %b expected 00", gntTr[16]); end
    testsRun++; if (validTr[8] !== 1'b0) begin failCount++; $display("[TB] FAIL midrst_valid_late: got %b expected 0", validTr[8]); end
    testsRun++; if (validTr[9] !== 1'b1) begin failCount++; $display("[TB] FAIL midrst_valid_start: got %b expected 1", validTr[9]); end
  endtask

  task automatic test_req_withdrawn;
    doReset();
    @(negedge clk);
    req = 2'b01;
    #2;
    req = 2'b00;
    runCycles(5, 1'b1);
    for (int i = 0; i < 5; i++) begin
      testsRun++; if (gntTr[i] !== 2'b00) begin failCount++; $display("[TB] FAIL withdrawn_gnt[%0d]: got %b expected 00", i, gntTr[i]); end
      testsRun++; if (busyTr[i] !== 1'b0) begin failCount++; $display("[TB] FAIL withdrawn_busy[%0d]: got %b expected 0", i, busyTr[i]); end
    end
  endtask

  // Run every scenario in order, then report.
  initial begin
    testsRun  = 0;
    failCount = 0;
    pat0 = 16'h0000;
    pat1 = 16'h0000;
    test_reset();
    test_prefill_mask();
    test_single_frame();
    test_back_to_back();
    test_fairness();
    test_reset_mid_run();
    test_req_withdrawn();
    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
